dual_port_synch_ram_init: RTL
=============================

DUAL_PORT_SYNCH_RAM_INIT -- requirements
Module: dual_port_synch_ram_init

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, data word width; a multiple of 8, minimum 8.
REQ-002 SHALL have parameter DEPTH, default 16, number of words; 2 to 1024, power of two not required.
REQ-003 SHALL have parameter RD_LATENCY, default 1, read latency in cycles; legal values 1 or 2.
REQ-004 SHALL have parameter BYPASS, default 1, same-address read-during-write mode; 1 = new data, 0 = old data.
REQ-005 SHALL derive ADDR_WIDTH = max(1, clog2(DEPTH)) and BE_WIDTH = DATA_WIDTH/8 as localparams.
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 rst  input  1  reset, asynchronous assert, active-low.
REQ-008 clr  input  1  synchronous request to zero the whole array.
REQ-009 wr_enb  input  1  write request.
REQ-010 wr_addr  input  ADDR_WIDTH  write address.
REQ-011 wr_be  input  BE_WIDTH  byte enables; bit k writes data_in[8k+7:8k].
REQ-012 data_in  input  DATA_WIDTH  write data.
REQ-013 rd_enb  input  1  read request.
REQ-014 rd_addr  input  ADDR_WIDTH  read address.
REQ-015 data_out  output  DATA_WIDTH  registered read data.
REQ-016 rd_valid  output  1  one-cycle pulse qualifying data_out.
REQ-017 busy  output  1  high while the array is being cleared; requests are ignored.

Function
REQ-018 SHALL implement a two-state FSM: INIT and READY.
REQ-019 In INIT, SHALL write zero to one address per cycle, counting 0 to DEPTH-1, and SHALL go to READY after the DEPTH-1 write.
REQ-020 A full clear SHALL therefore take exactly DEPTH cycles with busy=1; busy SHALL fall in the first READY cycle.
REQ-021 In INIT, wr_enb and rd_enb SHALL be ignored, with no memory update and no rd_valid.
REQ-022 In READY, clr=1 SHALL move to INIT with the counter at 0; a write in the same cycle as clr SHALL be dropped.
REQ-023 clr=1 during INIT SHALL restart the counter at 0.
REQ-024 In READY, wr_enb=1 SHALL update only the bytes selected by wr_be; wr_be=0 SHALL leave the word unchanged.
REQ-025 rd_enb=1 in READY at edge N SHALL drive data_out and rd_valid=1 at edge N+RD_LATENCY.
REQ-026 rd_valid SHALL be 0 otherwise, and data_out SHALL hold its last value.
REQ-027 For a same-cycle read and write to the same address with BYPASS=1, the read SHALL return the old word merged with the written bytes.
REQ-028 For a same-cycle read and write to the same address with BYPASS=0, the read SHALL return the pre-write word.
REQ-029 Addresses >= DEPTH SHALL be handled as follows: write ignored; read returns 0 with rd_valid=1.
REQ-030 Reads already in the pipeline when clr is accepted SHALL complete with pre-clear data.
REQ-031 Back-to-back reads SHALL sustain one result per cycle at either latency.

Reset
REQ-032 rst low SHALL asynchronously force: FSM=INIT, counter=0, busy=1, rd_valid=0, data_out=0, read pipeline cleared.
REQ-033 The memory array SHALL NOT be reset directly; it SHALL be zeroed by the INIT sweep after rst rises.
REQ-034 Reset asserted mid-INIT or mid-read SHALL abort the operation; the sweep SHALL restart from 0 after release.

Structure
REQ-035 A shared package SHALL hold the FSM state enum (INIT, READY) and the legal RD_LATENCY/BYPASS constants.
REQ-036 The storage array SHALL be a sub-module, dp_ram_core: plain byte-enabled write port plus registered read port, no reset.
REQ-037 The FSM, address mux, bypass merge, out-of-range check and latency pipeline SHALL live in the top module.

Verification
REQ-038 Default parameters; release rst -> busy=1 for exactly 16 cycles, then 0; read every address -> 0x00 with rd_valid at N+1.
REQ-039 Write 0xA5 at addr 3, then read addr 3 -> data_out=0xA5. Then clr -> busy 16 cycles; read addr 3 -> 0x00.
REQ-040 DATA_WIDTH=32: write 0x11223344 at addr 5; write 0xAABBCCDD at addr 5 with wr_be=4'b0101; read addr 5 -> 0x11BB33DD.
REQ-041 Addr 7 holds 0x10; same-cycle write 0x20 and read at addr 7 -> 0x20 with BYPASS=1, 0x10 with BYPASS=0.
REQ-042 DEPTH=12, RD_LATENCY=2: write to addr 13 is ignored; read addr 13 -> 0 with rd_valid at N+2.
REQ-043 Streaming reads at RD_LATENCY=2 -> one result per cycle. Pull rst low at sweep address 6 -> outputs reset immediately; full 12-cycle sweep after release.

Source files
------------

// File: rtl/dual_port_synch_ram_init_pkg.sv
// rtl/dual_port_synch_ram_init_pkg.sv - shared FSM state type and legal parameter values
package dual_port_synch_ram_init_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  localparam int BYPASS_OLD = 0;
  localparam int BYPASS_NEW = 1;

endpackage

// File: rtl/dp_ram_core.sv
// rtl/dp_ram_core.sv - byte-enabled write port plus registered read port, no reset
module dp_ram_core #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [BE_WIDTH-1:0]   wbe,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Read-before-write: a same-edge read sees the pre-write word.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < BE_WIDTH; b++) begin
        if (wbe[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/dual_port_synch_ram_init.sv
// rtl/dual_port_synch_ram_init.sv - dual-port RAM with init/clear sweep, bypass and read pipeline
module dual_port_synch_ram_init
  import dual_port_synch_ram_init_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 16,
  parameter int RD_LATENCY  = RD_LAT_MIN,
  parameter int BYPASS      = BYPASS_NEW,
  localparam int ADDR_WIDTH = (DEPTH > 2) ? $clog2(DEPTH) : 1,
  localparam int BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  wr_enb,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [BE_WIDTH-1:0]   wr_be,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_enb,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  busy
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;

  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_waddr;
  logic [BE_WIDTH-1:0]   ram_wbe;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic                  ram_re;
  logic [DATA_WIDTH-1:0] ram_rdata;

  logic wr_ok, rd_ok, rd_oor, rd_hit;

  logic                  v1, oor1, hit1;
  logic [BE_WIDTH-1:0]   hit_be1;
  logic [DATA_WIDTH-1:0] hit_data1;
  logic [DATA_WIDTH-1:0] merged;
  logic                  out_v;
  logic [DATA_WIDTH-1:0] out_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      INIT: begin
        if (clr) begin
          cnt_nxt = '0;
        end else if (cnt == LAST_ADDR) begin
          state_nxt = READY;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      READY: begin
        if (clr) begin
          state_nxt = INIT;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = INIT;
        cnt_nxt   = '0;
      end
    endcase
  end

  // A write coinciding with clr is dropped; out-of-range writes never reach the array.
  assign wr_ok  = (state == READY) && wr_enb && !clr && ({1'b0, wr_addr} < DEPTH_W);
  assign rd_ok  = (state == READY) && rd_enb;
  assign rd_oor = ({1'b0, rd_addr} >= DEPTH_W);
  assign rd_hit = (BYPASS == BYPASS_NEW) && wr_ok && (wr_addr == rd_addr);
  assign ram_re = rd_ok && !rd_oor;

  always_comb begin
    busy      = 1'b1;
    ram_we    = 1'b0;
    ram_waddr = wr_addr;
    ram_wbe   = wr_be;
    ram_wdata = data_in;
    case (state)
      INIT: begin
        busy      = 1'b1;
        ram_we    = 1'b1;
        ram_waddr = cnt;
        ram_wbe   = '1;
        ram_wdata = '0;
      end
      READY: begin
        busy   = 1'b0;
        ram_we = wr_ok;
      end
      default: begin
        busy   = 1'b1;
        ram_we = 1'b0;
      end
    endcase
  end

  dp_ram_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .BE_WIDTH   (BE_WIDTH)
  ) u_core (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wbe   (ram_wbe),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (rd_addr),
    .rdata (ram_rdata)
  );

  // Side information travels alongside the core's registered read word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1        <= 1'b0;
      oor1      <= 1'b0;
      hit1      <= 1'b0;
      hit_be1   <= '0;
      hit_data1 <= '0;
    end else begin
      v1 <= rd_ok;
      if (rd_ok) begin
        oor1      <= rd_oor;
        hit1      <= rd_hit;
        hit_be1   <= wr_be;
        hit_data1 <= data_in;
      end
    end
  end

  always_comb begin
    merged = ram_rdata;
    if (hit1) begin
      for (int b = 0; b < BE_WIDTH; b++) begin
        if (hit_be1[b]) merged[8*b +: 8] = hit_data1[8*b +: 8];
      end
    end
    if (oor1) merged = '0;
  end

  if (RD_LATENCY == RD_LAT_MAX) begin : g_lat2
    logic                  v2;
    logic [DATA_WIDTH-1:0] d2;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        v2 <= 1'b0;
        d2 <= '0;
      end else begin
        v2 <= v1;
        if (v1) d2 <= merged;
      end
    end
    assign out_v = v2;
    assign out_d = d2;
  end else begin : g_lat1
    assign out_v = v1;
    assign out_d = merged;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid <= 1'b0;
      data_out <= '0;
    end else begin
      rd_valid <= out_v;
      if (out_v) data_out <= out_d;
    end
  end

endmodule
